rx_deserial_fifo: RTL and testbench
===================================

// Module: rx_deserial_fifo
// PURPOSE
//  Receive-side partner of the transmit PISO FIFO. Deserialises frames from the Tx serial line,
//  checks parity and the stop bit, and buffers good frames in a DEPTH-entry FIFO for the host.
//  Drives Rx_ready back to the transmitter so the Tx side waits instead of overrunning this FIFO.
// PARAMETERS
//  FIFO_DEPTH_R  16  entries; power of 2, >=2
//  DATA_W        8   payload bits per frame
//  PARITY_ODD    0   0: even parity expected ({data,p} XOR == 0); 1: odd parity expected
// PORTS
//  baud_clk     in   1        one bit period per clock; all logic on posedge
//  rst          in   1        asynchronous, active-high
//  serial_in    in   1        Tx line; idle high
//  rd_en        in   1        host read request
//  data_out     out  DATA_W   read data, registered
//  data_valid   out  1        1-cycle pulse: data_out/parity_err valid
//  parity_err   out  1        parity error flag stored with the word on data_out
//  frame_err    out  1        1-cycle pulse: stop bit sampled 0
//  overrun      out  1        1-cycle pulse: good frame dropped because FIFO full
//  RxFF         out  1        FIFO full (count == FIFO_DEPTH_R)
//  RxFE         out  1        FIFO empty (count == 0)
//  Rx_ready     out  1        combinational: (state == IDLE) && !RxFF
// BEHAVIOUR
//  Frame, one bit per baud_clk: start(0), d0..d7 LSB first, parity, stop(1); 11 cycles total.
//  Reset (async, any time incl. mid-frame):
//   - FSM -> IDLE; shift reg, bit_cnt, pointers and count cleared; frame discarded.
//   - data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, RxFE=1, RxFF=0.
//  FSM:
//   - IDLE: serial_in==0 -> DATA with bit_cnt=0; otherwise stay.
//   - DATA: shift[bit_cnt] <= serial_in. bit_cnt 0..7 is data, 8 is parity; bit_cnt==8 -> STOP.
//   - STOP: serial_in==1 -> attempt write, go IDLE.
//           serial_in==0 -> frame_err pulse, no write, go BREAK.
//   - BREAK: stay until serial_in==1, then IDLE (a held-low line never starts a false frame).
//  Write: word = {perr, data[7:0]}; perr = (^shift[8:0]) != PARITY_ODD.
//   - Accepted if count < FIFO_DEPTH_R, or a read is accepted in the same cycle.
//   - Otherwise overrun pulses and the word is dropped.
//   - Parity-bad words are stored, not dropped; perr travels with them.
//  Read: rd_en && !RxFE -> next cycle data_out/parity_err <= mem[rd_ptr], data_valid=1, rd_ptr++.
//   - rd_en while empty is ignored: no pulse, no pointer change. data_out holds its last value.
//  Pointers: $clog2(FIFO_DEPTH_R) bits, wrap naturally.
//   - count is one bit wider. Same-cycle read+write leaves count unchanged.
//   - RxFF/RxFE are registered from next-cycle count.
//  Latency: stop-bit cycle -> RxFE falls next edge; rd_en -> data_valid 1 cycle.
//  Rx_ready is low during DATA/STOP/BREAK, and while full.
// STRUCTURE
//  Shared header uart_defs.vh:
//   - localparams FRAME_BITS=11, PAYLOAD_BITS=9.
//   - State encodings IDLE/DATA/STOP/BREAK; reused by the Tx FIFO bench.
//  One sub-module: sync_fifo_mem (storage, pointers, count, full/empty, registered read port).
//  This top holds the FSM, shift reg, parity/stop checks and error pulses.
// TESTING
//  1 Frame 0xA5, even parity bit 0, stop 1; rd_en -> data_out=0xA5, parity_err=0, data_valid 1 cycle.
//  2 0x01 with parity 0 (even mode) -> stored; on read parity_err=1, data_out=0x01.
//  3 0x3C with stop=0 -> frame_err pulse, RxFE stays 1.
//     Hold line low 5 cycles, then 1 -> no extra frames; next good 0x3C accepted.
//  4 17 frames 0x00..0x10, no reads -> RxFF=1 after 16th, overrun on 17th, Rx_ready=0.
//     Then 16 reads return 0x00..0x0F in order, RxFE=1.
//  5 Full FIFO, rd_en asserted in the stop cycle of frame 0x55 -> no overrun, RxFF stays 1.
//     0x55 is read last.
//  6 rst pulsed at bit 4 of frame 0xFF -> all outputs at reset values, RxFE=1.
//     Following 0x12 received correctly.

Source files
------------

// File: rtl/rx_deserial_fifo_pkg.sv
// Shared definitions for the serial receive path: frame geometry and
// receiver FSM state encodings (also used by the transmit-side bench).
package rx_deserial_fifo_pkg;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS   = 11;
  // data bits plus parity bit captured by the shift register
  localparam int PAYLOAD_BITS = 9;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_DATA  = 2'd1,
    RX_STOP  = 2'd2,
    RX_BREAK = 2'd3
  } rx_state_t;

endpackage : rx_deserial_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// Synchronous FIFO storage: memory, pointers, occupancy count, registered
// full/empty flags and a registered read port with a one-cycle valid pulse.
// A write into a full FIFO is still accepted when a read is accepted in the
// same cycle; otherwise it is dropped and reported on wr_drop.
module sync_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             baud_clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             wr_drop
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r;
  logic             rd_ok_s;
  logic             wr_ok_s;
  logic             wr_drop_s;

  // Accept/drop decisions and next occupancy count
  always_comb begin
    rd_ok_s     = rd_en && !empty_r;
    wr_ok_s     = wr_en && (!full_r || rd_ok_s);
    wr_drop_s   = wr_en && !wr_ok_s;
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; contents need no reset because the pointers gate reads
  always_ff @(posedge baud_clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, count, flags and registered read port
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        rd_data_r <= mem_r[rd_ptr_r];
      end
      rd_valid_r <= rd_ok_s;
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == CNT_MAX);
      empty_r    <= (count_nxt_s == '0);
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign full     = full_r;
  assign empty    = empty_r;
  assign wr_drop  = wr_drop_s;

endmodule : sync_fifo_mem

// File: rtl/rx_deserial_fifo.sv
// Serial frame receiver: deserialises start/data/parity/stop frames, checks
// parity and stop bit, pushes {parity_err, data} into a FIFO and throttles
// the transmitter through Rx_ready.
module rx_deserial_fifo
  import rx_deserial_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH_R = 16,
  parameter int DATA_W       = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              baud_clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              RxFF,
  output logic              RxFE,
  output logic              Rx_ready
);

  localparam int            CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  rx_state_t         state_r;
  rx_state_t         state_nxt_s;
  logic [CW-1:0]     bit_cnt_r;
  logic [DATA_W:0]   shift_r;
  logic              wr_req_s;
  logic              frame_err_s;
  logic              frame_err_r;
  logic              overrun_r;
  logic              wr_drop_s;
  logic              full_s;
  logic              empty_s;
  logic              rd_valid_s;
  logic [DATA_W:0]   wr_word_s;
  logic [DATA_W:0]   rd_word_s;

  // Parity check over data plus received parity bit
  function automatic logic calc_perr(input logic [DATA_W:0] word);
    return (^word) != PARITY_ODD;
  endfunction

  // Next-state decode; a write is requested only on a good stop bit
  always_comb begin
    state_nxt_s = state_r;
    wr_req_s    = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (!serial_in) begin
          state_nxt_s = RX_DATA;
        end else begin
          state_nxt_s = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (bit_cnt_r == LAST_BIT) begin
          state_nxt_s = RX_STOP;
        end else begin
          state_nxt_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (serial_in) begin
          wr_req_s    = 1'b1;
          state_nxt_s = RX_IDLE;
        end else begin
          frame_err_s = 1'b1;
          state_nxt_s = RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (serial_in) begin
          state_nxt_s = RX_IDLE;
        end else begin
          state_nxt_s = RX_BREAK;
        end
      end
      default: state_nxt_s = RX_IDLE;
    endcase
  end

  // State register, bit counter, shift register and error pulses
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_r     <= RX_IDLE;
      bit_cnt_r   <= '0;
      shift_r     <= '0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      frame_err_r <= frame_err_s;
      overrun_r   <= wr_drop_s;
      case (state_r)
        RX_IDLE: bit_cnt_r <= '0;
        RX_DATA: begin
          shift_r[bit_cnt_r] <= serial_in;
          bit_cnt_r          <= bit_cnt_r + CNT_ONE;
        end
        default: bit_cnt_r <= bit_cnt_r;
      endcase
    end
  end

  assign wr_word_s = {calc_perr(shift_r), shift_r[DATA_W-1:0]};

  sync_fifo_mem #(
    .DEPTH (FIFO_DEPTH_R),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .baud_clk (baud_clk),
    .rst      (rst),
    .wr_en    (wr_req_s),
    .wr_data  (wr_word_s),
    .rd_en    (rd_en),
    .rd_data  (rd_word_s),
    .rd_valid (rd_valid_s),
    .full     (full_s),
    .empty    (empty_s),
    .wr_drop  (wr_drop_s)
  );

  assign data_out   = rd_word_s[DATA_W-1:0];
  assign parity_err = rd_word_s[DATA_W];
  assign data_valid = rd_valid_s;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign RxFF       = full_s;
  assign RxFE       = empty_s;
  assign Rx_ready   = (state_r == RX_IDLE) && !full_s;

endmodule : rx_deserial_fifo

// File: tb/tb_rx_deserial_fifo.sv
// Scoreboard bench for rx_deserial_fifo: stimulus pushes expected words,
// a monitor pops and compares on every data_valid pulse.
module tb_rx_deserial_fifo;

  logic       baud_clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       RxFF;
  logic       RxFE;
  logic       Rx_ready;

  int checks = 0;
  int passes = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  int fe_exp = 0;
  int ov_exp = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  rx_deserial_fifo dut (
    .baud_clk   (baud_clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .RxFF       (RxFF),
    .RxFE       (RxFE),
    .Rx_ready   (Rx_ready)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: count error pulses, compare every read word against the scoreboard
  always @(posedge baud_clk) begin
    #1;
    if (frame_err === 1'b1) fe_seen++;
    if (overrun === 1'b1) ov_seen++;
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_read: got 0x%0h with nothing expected", {parity_err, data_out});
      end else begin
        mon_exp = exp_q.pop_front();
        check("read_word", {23'd0, parity_err, data_out}, {23'd0, mon_exp});
      end
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge baud_clk);
    serial_in = b;
  endtask

  task automatic send_bits(input logic [7:0] d, input logic p, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(stop);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(d, ^d, 1'b1);
    drive_bit(1'b1);
  endtask

  task automatic read_one();
    @(negedge baud_clk);
    rd_en = 1'b1;
    @(negedge baud_clk);
    rd_en = 1'b0;
  endtask

  // {data_out, data_valid, parity_err, frame_err, overrun, RxFF, RxFE, Rx_ready}
  function automatic logic [31:0] out_vec();
    return {17'd0, data_out, data_valid, parity_err, frame_err, overrun, RxFF, RxFE, Rx_ready};
  endfunction

  localparam logic [31:0] RESET_VEC = 32'h0000_0003;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge baud_clk);
    rst = 1'b0;
    check("reset_outputs", out_vec(), RESET_VEC);

    // 1: good frame 0xA5, then an ignored read while empty
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5);
    check("t1_not_empty", {31'd0, RxFE}, 32'd0);
    read_one();
    check("t1_empty_after_read", {31'd0, RxFE}, 32'd1);
    read_one();
    check("t1_empty_read_no_pulse", {31'd0, data_valid}, 32'd0);
    check("t1_data_out_held", {24'd0, data_out}, 32'h0000_00A5);

    // 2: bad parity word stored with its flag
    exp_q.push_back({1'b1, 8'h01});
    send_bits(8'h01, 1'b0, 1'b1);
    drive_bit(1'b1);
    read_one();

    // 3: framing error, held-low line, then a good frame
    send_bits(8'h3C, 1'b0, 1'b0);
    fe_exp++;
    check("t3_empty_after_frame_err", {31'd0, RxFE}, 32'd1);
    repeat (5) drive_bit(1'b0);
    check("t3_not_ready_in_break", {31'd0, Rx_ready}, 32'd0);
    repeat (4) drive_bit(1'b1);
    check("t3_no_false_frame", {31'd0, RxFE}, 32'd1);
    check("t3_frame_err_count", fe_seen, fe_exp);
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'h3C);
    read_one();

    // 4: fill, overrun, drain
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back({1'b0, 8'(i)});
      send_frame(8'(i));
      if (i == 15) begin
        check("t4_full_after_16", {31'd0, RxFF}, 32'd1);
        check("t4_not_ready_full", {31'd0, Rx_ready}, 32'd0);
        check("t4_no_overrun_yet", ov_seen, ov_exp);
      end
    end
    ov_exp++;
    check("t4_overrun_count", ov_seen, ov_exp);
    check("t4_still_full", {31'd0, RxFF}, 32'd1);
    repeat (16) read_one();
    check("t4_empty_after_drain", {30'd0, RxFF, RxFE}, 32'd1);

    // 5: full FIFO, read in the stop cycle of frame 0x55
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({1'b0, 8'h20 + 8'(i)});
      send_frame(8'h20 + 8'(i));
    end
    exp_q.push_back({1'b0, 8'h55});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(((8'h55 >> i) & 8'h01) != 8'h00);
    drive_bit(1'b0);
    @(negedge baud_clk);
    serial_in = 1'b1;
    rd_en = 1'b1;
    @(negedge baud_clk);
    rd_en = 1'b0;
    check("t5_full_kept", {31'd0, RxFF}, 32'd1);
    check("t5_no_overrun", ov_seen, ov_exp);
    repeat (16) read_one();
    check("t5_empty_after_drain", {31'd0, RxFE}, 32'd1);

    // 6: reset in the middle of frame 0xFF with a word pending
    send_frame(8'h77);
    drive_bit(1'b0);
    repeat (4) drive_bit(1'b1);
    @(negedge baud_clk);
    #2 rst = 1'b1;
    #2;
    check("t6_outputs_in_reset", out_vec(), RESET_VEC);
    @(negedge baud_clk);
    rst = 1'b0;
    repeat (12) drive_bit(1'b1);
    check("t6_outputs_after_reset", out_vec(), RESET_VEC);
    exp_q.push_back({1'b0, 8'h12});
    send_frame(8'h12);
    read_one();
    check("t6_empty_end", {31'd0, RxFE}, 32'd1);

    repeat (3) @(negedge baud_clk);
    check("frame_err_total", fe_seen, fe_exp);
    check("overrun_total", ov_seen, ov_exp);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_rx_deserial_fifo
